// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP VRAM controller: CPU port select, control-byte
// opcodes, default address width and the RAM-port arbiter states.
package vdp_pkg;

    localparam int VDP_ADDR_W = 14;

    // cpu_port (a[0]) decode
    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTL  = 1'b1;

    // Second control byte, bits [7:6]
    localparam logic [1:0] CTL_REG  = 2'b10;
    localparam logic [1:0] CTL_WSET = 2'b01;
    localparam logic [1:0] CTL_RSET = 2'b00;

    // What the single RAM port was granted to in the previous cycle
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_VID,
        ARB_CPU_WR,
        ARB_CPU_RD
    } arb_state_t;

endpackage

// File: rtl/vdp_ctl_port.sv
// Two-byte control-port protocol: first byte lands in a latch, second byte
// either writes a register or loads the VRAM address. Also owns the
// auto-incrementing VRAM address.
module vdp_ctl_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VDP_ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr_stb,
    input  logic              cpu_rd_stb,
    input  logic              cpu_port,
    input  logic [7:0]        cpu_wdata,
    input  logic              addr_inc,
    output logic [63:0]       regs,
    output logic [ADDR_W-1:0] addr,
    output logic              rset_stb
);

    logic       ctl_flag;
    logic [7:0] latch;
    logic       ctl_wr;
    logic       ctl_rd;
    logic       data_acc;
    logic       second_byte;
    logic       addr_ld;
    logic [1:0] opcode;
    logic [13:0] ld_value;

    assign ctl_wr      = cpu_wr_stb && (cpu_port == PORT_CTL);
    assign ctl_rd      = cpu_rd_stb && (cpu_port == PORT_CTL);
    assign data_acc    = (cpu_wr_stb || cpu_rd_stb) && (cpu_port == PORT_DATA);
    assign second_byte = ctl_wr && ctl_flag;
    assign opcode      = cpu_wdata[7:6];
    assign addr_ld     = second_byte && ((opcode == CTL_WSET) || (opcode == CTL_RSET));
    assign rset_stb    = second_byte && (opcode == CTL_RSET);
    assign ld_value    = {cpu_wdata[5:0], latch};

    // Byte-pair sequencing: latch/flag on the first byte, register write on the second
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_flag <= 1'b0;
            latch    <= 8'h00;
            regs     <= 64'h0;
        end else if (ctl_wr) begin
            if (!ctl_flag) begin
                latch    <= cpu_wdata;
                ctl_flag <= 1'b1;
            end else begin
                ctl_flag <= 1'b0;
                if (opcode == CTL_REG) begin
                    regs[{cpu_wdata[2:0], 3'b000} +: 8] <= latch;
                end
            end
        end else if (ctl_rd || data_acc) begin
            ctl_flag <= 1'b0;
        end
    end

    // VRAM address: a fresh load from the control port beats a grant increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (addr_ld) begin
            addr <= ADDR_W'(ld_value);
        end else if (addr_inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/vdp_vram_ctrl.sv
// VRAM/register access sequencer for the VDP. Decodes CPU data/control port
// strobes, keeps a one-entry pending CPU op, and shares the single RAM port
// between video fetch (priority) and that op, with a bounded CPU wait.
//
// Handshake: CPU strobes are one-cycle pulses with no back-pressure. A strobe
// that needs the op slot is taken if the slot is empty or empties this same
// cycle; otherwise it is dropped and ovf_err latches. cpu_busy mirrors the
// slot. Video is a level request; each granted cycle yields vid_ack one cycle
// later with the byte on vid_rdata.
module vdp_vram_ctrl
    import vdp_pkg::*;
#(
    parameter int ADDR_W       = VDP_ADDR_W,
    parameter int CPU_MAX_WAIT = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr_stb,
    input  logic              cpu_rd_stb,
    input  logic              cpu_port,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              ovf_err,
    output logic [63:0]       regs,
    input  logic              vblank,
    output logic              int_out,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

    arb_state_t        state;
    arb_state_t        grant;
    logic              slot_full;
    logic              slot_rd;
    logic [7:0]        slot_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        rd_buf;
    logic              f_flag;
    logic [ADDR_W-1:0] addr;
    logic              rset_stb;
    logic              data_wr;
    logic              data_rd;
    logic              ctl_rd;
    logic              need_slot;
    logic              slot_done;
    logic              slot_free;
    logic              rd_inflight;
    logic              grant_cpu;

    vdp_ctl_port #(
        .ADDR_W (ADDR_W)
    ) u_ctl_port (
        .clk        (clk),
        .reset      (reset),
        .cpu_wr_stb (cpu_wr_stb),
        .cpu_rd_stb (cpu_rd_stb),
        .cpu_port   (cpu_port),
        .cpu_wdata  (cpu_wdata),
        .addr_inc   (grant_cpu),
        .regs       (regs),
        .addr       (addr),
        .rset_stb   (rset_stb)
    );

    assign data_wr     = cpu_wr_stb && (cpu_port == PORT_DATA);
    assign data_rd     = cpu_rd_stb && (cpu_port == PORT_DATA);
    assign ctl_rd      = cpu_rd_stb && (cpu_port == PORT_CTL);
    assign need_slot   = data_wr || data_rd || rset_stb;
    assign rd_inflight = (state == ARB_CPU_RD);
    assign grant_cpu   = (grant == ARB_CPU_WR) || (grant == ARB_CPU_RD);
    // A write frees the slot on its grant cycle, a prefetch when the buffer loads
    assign slot_done   = (grant == ARB_CPU_WR) || rd_inflight;
    assign slot_free   = !slot_full || slot_done;

    // Per-cycle RAM port arbitration: video first unless the CPU has waited too long
    always_comb begin
        grant = ARB_IDLE;
        if (vid_req && (wait_cnt < WAIT_W'(CPU_MAX_WAIT))) begin
            grant = ARB_VID;
        end else if (slot_full && !rd_inflight) begin
            grant = slot_rd ? ARB_CPU_RD : ARB_CPU_WR;
        end
    end

    assign mem_addr  = (grant == ARB_VID) ? vid_addr : (grant_cpu ? addr : '0);
    assign mem_we    = (grant == ARB_CPU_WR);
    assign mem_wdata = mem_we ? slot_data : 8'h00;

    assign cpu_busy  = slot_full;
    assign cpu_rdata = (cpu_port == PORT_DATA) ? rd_buf : {f_flag, 7'b0};
    assign int_out   = f_flag && regs[13];
    assign vid_rdata = vid_ack ? mem_rdata : 8'h00;

    // Arbiter state: remembers last cycle's grant so read data can be steered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB_IDLE;
            vid_ack <= 1'b0;
        end else begin
            state   <= grant;
            vid_ack <= (grant == ARB_VID);
        end
    end

    // One-entry CPU op slot; a refill may land in the cycle the slot drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_full <= 1'b0;
            slot_rd   <= 1'b0;
            slot_data <= 8'h00;
            ovf_err   <= 1'b0;
        end else begin
            if (need_slot && slot_free) begin
                slot_full <= 1'b1;
                slot_rd   <= !data_wr;
                slot_data <= cpu_wdata;
            end else if (slot_done) begin
                slot_full <= 1'b0;
            end
            if (need_slot && !slot_free) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // CPU starvation counter: counts pending, ungranted cycles up to the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (grant_cpu) begin
            wait_cnt <= '0;
        end else if (slot_full && !rd_inflight && (wait_cnt < WAIT_W'(CPU_MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Read-ahead buffer loads the cycle after a prefetch grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_buf <= 8'h00;
        end else if (rd_inflight) begin
            rd_buf <= mem_rdata;
        end
    end

    // Status F flag: set by vblank, cleared by a status read, vblank wins a tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_flag <= 1'b0;
        end else if (vblank) begin
            f_flag <= 1'b1;
        end else if (ctl_rd) begin
            f_flag <= 1'b0;
        end
    end

endmodule
